// File: rtl/pad_out_serializer_pkg.sv
// Shared types for the pad output serializer: FSM state encoding and
// the bit-counter width helper.
package pad_out_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  function automatic int bit_cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/pad_out_bit_timer.sv
// Loadable down-counter that marks the last cycle of each bit period
// (div+1 cycles per bit); reloads itself at every bit boundary.
module pad_out_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div;
    end else if (en) begin
      cnt <= bit_end ? div : (cnt - DIV_W'(1));
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/pad_out_serializer_sva.sv
// Protocol checker bound into the serializer in simulation builds:
// output enable, busy and handshake consistency.
module pad_out_serializer_sva
  import pad_out_serializer_pkg::*;
(
  input logic   clk,
  input logic   rst,
  input state_t state,
  input logic   pad_oe,
  input logic   busy,
  input logic   done,
  input logic   ready
);

  a_oe_only_outside_idle: assert property (@(posedge clk) disable iff (rst)
    pad_oe == (state != IDLE));

  a_busy_matches_state: assert property (@(posedge clk) disable iff (rst)
    busy == (state != IDLE));

  a_done_implies_ready: assert property (@(posedge clk) disable iff (rst)
    done |-> ready);

  a_no_accept_in_turnaround: assert property (@(posedge clk) disable iff (rst)
    ((state == TRAIL) || (state == DRIVE)) |-> !ready);

endmodule

// File: rtl/pad_out_serializer.sv
// Serializes parallel words onto one pad cell, owning output enable and
// the idle-level turnaround around each burst.
module pad_out_serializer
  import pad_out_serializer_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 8,
  parameter int PAD_ATTR    = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DIV_W-1:0]    div_i,
  input  logic                msb_first_i,
  input  logic                idle_level_i,
  input  logic [PAD_ATTR-1:0] attr_i,
  output logic                pad_in_o,
  output logic                pad_oe_o,
  output logic [PAD_ATTR-1:0] pad_attributes_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int BCNT_W    = bit_cnt_w(DATA_W);
  localparam int TURN_W    = (TURN_CYCLES > 2) ? $clog2(TURN_CYCLES) : 1;
  localparam int TURN_LOAD = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

  localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(DATA_W - 1);
  localparam logic [TURN_W-1:0] TURN_INIT   = TURN_W'(TURN_LOAD);
  localparam state_t            FIRST_STATE = (TURN_CYCLES > 0) ? DRIVE : SHIFT;
  localparam state_t            AFTER_STATE = (TURN_CYCLES > 0) ? TRAIL : IDLE;

  state_t              state, state_n;
  logic [DATA_W-1:0]   sreg, sreg_n;
  logic [DIV_W-1:0]    div_q, div_n;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;
  logic [TURN_W-1:0]   turn_cnt, turn_n;
  logic                accept, last_bit, bit_end;
  logic                timer_start, timer_en;

  // Words are stored already in transmit order so the shifter always
  // sends sreg[bcnt]; this also freezes the order flag at acceptance.
  function automatic logic [DATA_W-1:0] order_word(input logic [DATA_W-1:0] d,
                                                   input logic msb_first);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = msb_first ? d[DATA_W-1-i] : d[i];
    end
    return r;
  endfunction

  assign last_bit = (state == SHIFT) && bit_end && (bcnt == LAST_BIT);
  assign ready_o  = (state == IDLE) || last_bit;
  assign accept   = valid_i && ready_o;
  assign done_o   = last_bit;
  assign busy_o   = (state != IDLE);

  pad_out_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (timer_start),
    .en      (timer_en),
    .div     (div_n),
    .bit_end (bit_end)
  );

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    div_n       = div_q;
    bcnt_n      = bcnt;
    turn_n      = turn_cnt;
    timer_start = 1'b0;
    timer_en    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n     = FIRST_STATE;
          turn_n      = TURN_INIT;
          timer_start = (TURN_CYCLES == 0);
        end
      end
      DRIVE: begin
        if (turn_cnt == '0) begin
          state_n     = SHIFT;
          timer_start = 1'b1;
        end else begin
          turn_n = turn_cnt - TURN_W'(1);
        end
      end
      SHIFT: begin
        timer_en = 1'b1;
        if (bit_end) begin
          if (bcnt == LAST_BIT) begin
            if (accept) begin
              timer_start = 1'b1;
            end else begin
              state_n = AFTER_STATE;
              turn_n  = TURN_INIT;
            end
          end else begin
            bcnt_n = bcnt + BCNT_W'(1);
          end
        end
      end
      TRAIL: begin
        if (turn_cnt == '0) begin
          state_n = IDLE;
        end else begin
          turn_n = turn_cnt - TURN_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      sreg_n = order_word(data_i, msb_first_i);
      div_n  = div_i;
      bcnt_n = '0;
    end
  end

  // Pad register stage: outputs follow the next state so the pad value and
  // the FSM state change on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      bcnt             <= '0;
      turn_cnt         <= '0;
      pad_in_o         <= 1'b0;
      pad_oe_o         <= 1'b0;
      pad_attributes_o <= '0;
    end else begin
      state            <= state_n;
      bcnt             <= bcnt_n;
      turn_cnt         <= turn_n;
      pad_in_o         <= (state_n == SHIFT) ? sreg_n[bcnt_n] : idle_level_i;
      pad_oe_o         <= (state_n != IDLE);
      pad_attributes_o <= attr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    sreg  <= sreg_n;
    div_q <= div_n;
  end

`ifndef SYNTHESIS
  pad_out_serializer_sva u_sva (
    .clk    (clk_i),
    .rst    (rst_i),
    .state  (state),
    .pad_oe (pad_oe_o),
    .busy   (busy_o),
    .done   (done_o),
    .ready  (ready_o)
  );
`endif

endmodule

// File: tb/tb_pad_out_serializer.sv
// Self-checking bench: per-cycle pad waveform compared against a burst model
// built from the word list, bit order, divider and turnaround length.
module tb_pad_out_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data;
  logic        valid;
  logic [7:0]  div;
  logic        msb;
  logic        idle;
  logic [15:0] attr;
  logic        sel_b;
  logic        valid_a, valid_b;

  logic        ready_a, pad_a, oe_a, busy_a, done_a;
  logic        ready_b, pad_b, oe_b, busy_b, done_b;
  logic [15:0] attr_a, attr_b;

  assign valid_a = valid & ~sel_b;
  assign valid_b = valid & sel_b;

  always #5 clk = ~clk;

  pad_out_serializer #(.DATA_W(8), .DIV_W(8), .PAD_ATTR(16), .TURN_CYCLES(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_a), .ready_o(ready_a),
    .div_i(div), .msb_first_i(msb), .idle_level_i(idle), .attr_i(attr),
    .pad_in_o(pad_a), .pad_oe_o(oe_a), .pad_attributes_o(attr_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  pad_out_serializer #(.DATA_W(8), .DIV_W(8), .PAD_ATTR(16), .TURN_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_b), .ready_o(ready_b),
    .div_i(div), .msb_first_i(msb), .idle_level_i(idle), .attr_i(attr),
    .pad_in_o(pad_b), .pad_oe_o(oe_b), .pad_attributes_o(attr_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  typedef struct {
    logic [7:0] d;
    int         dv;
    bit         msb;
  } word_t;

  int          errors = 0;
  int          checks = 0;
  word_t       words[$];
  logic [4:0]  exp_q[$];
  int          kind_q[$];
  int          widx_q[$];
  int          done_pos[$];
  int          busy_cycles;
  logic [15:0] attr_prev;

  function automatic word_t mk(input logic [7:0] d, input int dv, input bit m);
    word_t w;
    w.d = d; w.dv = dv; w.msb = m;
    return w;
  endfunction

  // {oe, pad, busy, done, ready} of the selected DUT
  function automatic logic [4:0] get_obs();
    return sel_b ? {oe_b, pad_b, busy_b, done_b, ready_b}
                 : {oe_a, pad_a, busy_a, done_a, ready_a};
  endfunction

  function automatic logic [15:0] get_attr();
    return sel_b ? attr_b : attr_a;
  endfunction

  // Expected cycles after acceptance: turnaround, every bit held dv+1
  // cycles, turnaround, then one idle cycle.
  // kind: -1 drive/bit, >=0 last cycle of word kind, -2 trail, -3 idle.
  function automatic void build_expected(input int turn, input logic idl);
    exp_q.delete(); kind_q.delete(); widx_q.delete();
    for (int t = 0; t < turn; t++) begin
      exp_q.push_back({1'b1, idl, 1'b1, 1'b0, 1'b0}); kind_q.push_back(-1); widx_q.push_back(0);
    end
    for (int i = 0; i < words.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        logic bv;
        bv = words[i].msb ? words[i].d[7-b] : words[i].d[b];
        for (int c = 0; c <= words[i].dv; c++) begin
          logic last;
          last = (b == 7) && (c == words[i].dv);
          exp_q.push_back({1'b1, bv, 1'b1, last, last});
          kind_q.push_back(last ? i : -1);
          widx_q.push_back(i);
        end
      end
    end
    for (int t = 0; t < turn; t++) begin
      exp_q.push_back({1'b1, idl, 1'b1, 1'b0, 1'b0}); kind_q.push_back(-2); widx_q.push_back(words.size());
    end
    exp_q.push_back({1'b0, idl, 1'b0, 1'b0, 1'b1}); kind_q.push_back(-3); widx_q.push_back(words.size());
  endfunction

  task automatic present(input word_t w);
    data = w.d; div = 8'(w.dv); msb = w.msb; valid = 1'b1;
  endtask

  task automatic garbage(input logic v);
    data = 8'($urandom); div = 8'($urandom); msb = 1'($urandom); valid = v;
  endtask

  task automatic run_burst(input string name, input bit hold, input bit trail_valid);
    int turn;
    logic [4:0] got;
    turn = sel_b ? 0 : 1;
    build_expected(turn, idle);
    done_pos.delete();
    busy_cycles = 0;
    attr = 16'($urandom); attr_prev = attr;
    @(negedge clk);
    got = get_obs();
    checks++;
    if (got !== {1'b0, idle, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s idle_before: oe,pad,busy,done,ready got %b expected %b", name, got, {1'b0, idle, 3'b001});
    end
    checks++;
    if (get_attr() !== attr_prev) begin
      errors++;
      $display("FAIL %s attr_before: got %h expected %h", name, get_attr(), attr_prev);
    end
    attr = 16'($urandom); attr_prev = attr;
    present(words[0]);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = get_obs();
      if (got[2]) busy_cycles++;
      if (got[1]) done_pos.push_back(k);
      checks++;
      if (got !== exp_q[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: oe,pad,busy,done,ready got %b expected %b", name, k, got, exp_q[k]);
      end
      checks++;
      if (get_attr() !== attr_prev) begin
        errors++;
        $display("FAIL %s attr cycle %0d: got %h expected %h", name, k, get_attr(), attr_prev);
      end
      attr = 16'($urandom); attr_prev = attr;
      if (kind_q[k] >= 0 && kind_q[k] + 1 < words.size()) present(words[kind_q[k] + 1]);
      else if (hold && kind_q[k] == -1 && widx_q[k] + 1 < words.size()) present(words[widx_q[k] + 1]);
      else if (trail_valid && kind_q[k] == -2) garbage(1'b1);
      else garbage(1'b0);
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    attr = 16'hBEEF;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({oe_a, pad_a, busy_a, done_a, oe_b, pad_b, busy_b} !== 7'b0 || attr_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: outputs got %b attr %h expected 0", {oe_a, pad_a, busy_a, done_a, oe_b, pad_b, busy_b}, attr_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({oe_a, pad_a, busy_a, done_a} !== 4'b0 || attr_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: outputs got %b attr %h expected 0", {oe_a, pad_a, busy_a, done_a}, attr_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ready_a, busy_a, ready_b, busy_b} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release: ready/busy got %b expected 1010", {ready_a, busy_a, ready_b, busy_b});
    end
  endtask

  task automatic test_basic_msb();
    sel_b = 1'b0; idle = 1'b1;
    words.delete(); words.push_back(mk(8'hA5, 0, 1'b1));
    run_burst("basic_msb", 1'b0, 1'b0);
  endtask

  task automatic test_lsb_div();
    sel_b = 1'b0; idle = 1'b1;
    words.delete(); words.push_back(mk(8'h01, 2, 1'b0));
    run_burst("lsb_div", 1'b0, 1'b1);
    checks++;
    if (busy_cycles !== 26) begin
      errors++;
      $display("FAIL lsb_div busy_cycles: got %0d expected 26", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    sel_b = 1'b0; idle = 1'b0;
    words.delete();
    words.push_back(mk(8'hF0, 0, 1'b1));
    words.push_back(mk(8'h0F, 0, 1'b1));
    run_burst("back_to_back", 1'b1, 1'b0);
    checks++;
    if (done_pos.size() != 2) begin
      errors++;
      $display("FAIL b2b done_count: got %0d expected 2", done_pos.size());
    end else if (done_pos[1] - done_pos[0] != 8) begin
      errors++;
      $display("FAIL b2b done_spacing: got %0d expected 8", done_pos[1] - done_pos[0]);
    end
  endtask

  task automatic test_turn0();
    sel_b = 1'b1; idle = 1'b0;
    words.delete(); words.push_back(mk(8'h80, 0, 1'b1));
    run_burst("turn0", 1'b0, 1'b0);
    sel_b = 1'b0;
  endtask

  task automatic test_config_change();
    sel_b = 1'b0; idle = 1'b1;
    words.delete(); words.push_back(mk(8'hC6, 1, 1'b1));
    run_burst("config_change", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    sel_b = 1'b0; idle = 1'b1;
    words.delete(); words.push_back(mk(8'hFF, 0, 1'b1));
    @(negedge clk);
    present(words[0]);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({oe_a, pad_a, busy_a} !== 3'b111) begin
      errors++;
      $display("FAIL mid_word_bit3: oe,pad,busy got %b expected 111", {oe_a, pad_a, busy_a});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({oe_a, pad_a, busy_a, done_a} !== 4'b0) begin
      errors++;
      $display("FAIL mid_word_abort: oe,pad,busy,done got %b expected 0000", {oe_a, pad_a, busy_a, done_a});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_word_ready: got %b expected 1", ready_a);
    end
    idle = 1'($urandom);
    words.delete(); words.push_back(mk(8'($urandom), $urandom_range(0, 2), 1'($urandom)));
    run_burst("post_reset", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n;
      sel_b = 1'($urandom);
      idle  = 1'($urandom);
      n = $urandom_range(1, 3);
      words.delete();
      for (int j = 0; j < n; j++) words.push_back(mk(8'($urandom), $urandom_range(0, 3), 1'($urandom)));
      run_burst($sformatf("random_%0d", it), 1'($urandom), 1'($urandom));
    end
    sel_b = 1'b0;
  endtask

  initial begin
    valid = 1'b0; data = '0; div = '0; msb = 1'b0; idle = 1'b0; attr = '0; sel_b = 1'b0;
    test_reset();
    test_basic_msb();
    test_lsb_div();
    test_back_to_back();
    test_turn0();
    test_config_change();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pad_out_serializer.md
Name: pad_out_serializer

Overview:
- Transmit-side companion to the input pad cell: takes parallel words over a valid/ready handshake and serializes them onto a single bidirectional/output pad cell.
- Drives the pad cell's output value, output enable and attributes.
- Owns turnaround: the pad is tristated when idle, and the idle level is driven for TURN_CYCLES before and after each burst.
- Sits between a peripheral (bit-bang/UART-like TX) and the pad ring.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- DIV_W, 8, width of the bit-period divider input.
- PAD_ATTR, 16, pad attribute bus width.
- TURN_CYCLES, 1, cycles of idle level driven with oe=1 before the first and after the last bit of a burst; 0 skips DRIVE/TRAIL.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  DATA_W  word to transmit.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block accepts data_i this cycle.
- div_i  in  DIV_W  bit period = div_i+1 clk cycles; sampled at acceptance.
- msb_first_i  in  1  bit order; sampled at acceptance.
- idle_level_i  in  1  level driven in DRIVE/TRAIL and tracked in IDLE.
- attr_i  in  PAD_ATTR  pad attributes requested.
- pad_in_o  out  1  value to pad cell (pad_in_i of cell).
- pad_oe_o  out  1  pad output enable.
- pad_attributes_o  out  PAD_ATTR  attributes to pad cell.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse on last cycle of each word.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, pad_in_o=0, pad_oe_o=0, pad_attributes_o=0, busy_o=0, done_o=0, ready_o=1 once rst_i deasserts. Assertion mid-word aborts immediately: pad tristated, word dropped.
- Registered outputs: pad_in_o, pad_oe_o, pad_attributes_o. pad_attributes_o follows attr_i with 1-cycle latency in all states.
- ready_o is combinational: 1 in IDLE, and in SHIFT on the last cycle of the last bit; otherwise 0.
- Handshake: transfer when valid_i & ready_o at a rising edge. data_i, div_i and msb_first_i are latched into the shift register, divider reload and order flag.
- IDLE:
  - pad_oe_o=0; pad_in_o tracks idle_level_i (1-cycle latency).
  - On transfer, go to DRIVE (or SHIFT if TURN_CYCLES=0).
- DRIVE:
  - pad_oe_o=1, pad_in_o=idle_level_i for exactly TURN_CYCLES cycles, then SHIFT.
- SHIFT:
  - pad_oe_o=1. Each bit is held for div_i+1 cycles; the bit counter runs 0..DATA_W-1.
  - msb_first_i=1 sends data[DATA_W-1] first; otherwise data[0] first.
  - div_i=0 gives one bit per cycle.
  - done_o=1 on the last cycle of bit DATA_W-1.
  - On that same cycle, if valid_i=1, the new word is accepted and its first bit follows with no gap and no DRIVE phase (back-to-back). Otherwise go to TRAIL (or IDLE if TURN_CYCLES=0).
- TRAIL:
  - pad_oe_o=1, pad_in_o=idle_level_i for TURN_CYCLES cycles, then IDLE (pad_oe_o=0 next cycle).
  - valid_i is ignored in TRAIL. A new word waits for IDLE and gets a fresh DRIVE.
- Divider counter width: DIV_W, down-counting, reloaded at each bit boundary. Changes to div_i or msb_first_i mid-word have no effect.
- Bit counter width: $clog2(DATA_W).
- Invariant: pad_oe_o=0 only in IDLE. The pad is never driven while the value register is undefined.

Decomposition:
- Package pad_out_serializer_pkg: state enum (IDLE, DRIVE, SHIFT, TRAIL, 2-bit) and the bit-counter width function.
- Sub-module pad_out_bit_timer: loadable down-counter producing a bit_end strobe from div. Reused by a future receiver-side sampler.
- Assertions live in a separate SVA include, guarded by `ifndef SYNTHESIS.

Test Plan:
- Basic MSB-first: DATA_W=8, TURN_CYCLES=1, div=0, idle=1. Send 0xA5.
  - Cycle after accept: oe=1, pad=1 (1 cycle).
  - Then 1,0,1,0,0,1,0,1, with done on the last bit.
  - Then pad=1 for 1 cycle, then oe=0.
- LSB-first with divider: 0x01, msb_first=0, div=2. Pad=1 for 3 cycles, then 0 for 21 cycles. busy_o high for 1+24+1=26 cycles.
- Back-to-back: 0xF0 then 0x0F, valid held, div=0.
  - ready_o pulses on the 8th bit cycle.
  - Pad shows 16 contiguous bits 1111000000001111 with one DRIVE before and one TRAIL after.
  - done_o pulses twice, 8 cycles apart.
- TURN_CYCLES=0: send 0x80 with idle=0. Bit 1 appears the cycle after accept, and oe drops the cycle after the last bit.
- Reset mid-word: assert rst_i during bit 3 of 0xFF. pad_oe_o=0, pad_in_o=0 and busy_o=0 immediately (asynchronous); ready_o=1 after release; the next word transmits cleanly.
- Mid-word config change: toggle div_i and msb_first_i during SHIFT. Bit timing and order are unchanged until the next accepted word.
